// File: rtl/net_orig_tx_pkg.sv
// Shared types and constants for the net_orig serial transmitter.
package net_orig_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Counter width for a range of n values, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/net_orig_serial_tx_if.sv
// Valid/ready word handshake feeding the serial transmitter.
interface net_orig_serial_tx_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/net_orig_tx_bittick.sv
// Bit-period counter: runs 0..DIV-1 and flags the last clock of each bit.
module net_orig_tx_bittick
  import net_orig_tx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  assign o_tick = (r_count == LAST);

  // Hold at zero while cleared, otherwise count and reload after the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/net_orig_serial_tx.sv
// Framed LSB-first serial transmitter driving the registered net_orig line.
module net_orig_serial_tx
  import net_orig_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  net_orig_serial_tx_if.slave  bus,
  output logic                 o_net_orig,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int IW = cnt_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  tx_state_e        r_state;
  tx_state_e        w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shifted;
  logic [IW-1:0]    r_idx;
  logic             r_parity;
  logic             r_net_orig;
  logic             w_next_line;
  logic             w_accept;
  logic             w_tick;
  logic             w_done;

  net_orig_tx_bittick #(
    .DIV(DIV)
  ) u_bittick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(r_state == IDLE),
    .o_tick (w_tick)
  );

  assign bus.in_ready = (r_state == IDLE);
  assign w_accept     = bus.in_valid && (r_state == IDLE);
  assign w_shifted    = r_shreg >> 1;
  assign o_net_orig   = r_net_orig;
  assign o_busy       = (r_state != IDLE);
  assign o_done       = w_done;

  // Next state plus the line level that state will present, so the line flop
  // changes on the same edge as the state.
  always_comb begin
    w_next_state = r_state;
    w_next_line  = IDLE_LEVEL;
    w_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = START;
          w_next_line  = START_LEVEL;
        end
      end
      START: begin
        if (w_tick) begin
          w_next_state = DATA;
          w_next_line  = r_shreg[0];
        end else begin
          w_next_line  = START_LEVEL;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_idx == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              w_next_state = PARITY;
              w_next_line  = r_parity;
            end else begin
              w_next_state = STOP;
              w_next_line  = IDLE_LEVEL;
            end
          end else begin
            w_next_line = w_shifted[0];
          end
        end else begin
          w_next_line = r_shreg[0];
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_next_state = STOP;
          w_next_line  = IDLE_LEVEL;
        end else begin
          w_next_line  = r_parity;
        end
      end
      STOP: begin
        w_next_line = IDLE_LEVEL;
        if (w_tick) begin
          w_next_state = IDLE;
          w_done       = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_line  = IDLE_LEVEL;
      end
    endcase
  end

  // State register and registered serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_net_orig <= IDLE_LEVEL;
    end else begin
      r_state    <= w_next_state;
      r_net_orig <= w_next_line;
    end
  end

  // Word capture on accept, then shift right once per data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg  <= '0;
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_shreg  <= bus.in_data;
      r_parity <= ^bus.in_data;
    end else if ((r_state == DATA) && w_tick) begin
      r_shreg  <= w_shifted;
    end
  end

  // Data bit index, restarted for every frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
    end else if ((r_state == DATA) && w_tick) begin
      if (r_idx == LAST_IDX) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_net_orig_serial_tx.sv
// Scoreboard bench: link A (DIV=4, parity) and link B (DIV=1, no parity).
module tb_net_orig_serial_tx;

  logic clk;
  logic rst_n;
  logic lineA, busyA, doneA;
  logic lineB, busyB, doneB;
  int   checks;
  int   errors;
  logic [8:0] qA[$];
  logic [8:0] qB[$];

  net_orig_serial_tx_if #(.WIDTH(8)) ifA ();
  net_orig_serial_tx_if #(.WIDTH(8)) ifB ();

  net_orig_serial_tx #(.WIDTH(8), .DIV(4), .PARITY_EN(1)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA),
    .o_net_orig(lineA), .o_busy(busyA), .o_done(doneA)
  );

  net_orig_serial_tx #(.WIDTH(8), .DIV(1), .PARITY_EN(0)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(ifB),
    .o_net_orig(lineB), .o_busy(busyB), .o_done(doneB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic lineOf(input int w);
    return (w == 0) ? lineA : lineB;
  endfunction

  function automatic logic doneOf(input int w);
    return (w == 0) ? doneA : doneB;
  endfunction

  function automatic logic busyOf(input int w);
    return (w == 0) ? busyA : busyB;
  endfunction

  function automatic logic readyOf(input int w);
    return (w == 0) ? ifA.in_ready : ifB.in_ready;
  endfunction

  // Offer a word; returns just after the accepting edge. Expected {parity,data}
  // is pushed when the word is taken.
  task automatic applyStimulus(input int w, input logic [7:0] data, input logic par,
                               input bit doExpect, input bit keepValid);
    bit taken;
    taken = 0;
    @(negedge clk);
    if (w == 0) begin ifA.in_valid = 1'b1; ifA.in_data = data; end
    else        begin ifB.in_valid = 1'b1; ifB.in_data = data; end
    for (int i = 0; i < 200; i++) begin
      if (i > 0) @(negedge clk);
      if (readyOf(w) === 1'b1) begin
        taken = 1;
        break;
      end
    end
    if (!taken) begin
      errors++;
      checks++;
      $display("[TB] FAIL accept timeout link %0d: ready never seen", w);
    end
    @(posedge clk);
    #1;
    if (taken && doExpect) begin
      if (w == 0) qA.push_back({par, data});
      else        qB.push_back({par, data});
    end
    if (!keepValid) begin
      if (w == 0) ifA.in_valid = 1'b0;
      else        ifB.in_valid = 1'b0;
    end
  endtask

  // Wait until every expected frame on a link has been observed.
  task automatic waitDrain(input int w);
    bit drained;
    drained = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (((w == 0) ? qA.size() : qB.size()) == 0 && busyOf(w) === 1'b0) begin
        drained = 1;
        break;
      end
    end
    if (!drained) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain timeout link %0d: frames still pending", w);
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: decode each frame from the line and compare with the queue head.
  task automatic monitorLink(input int w, input int div, input int par);
    int          total;
    int          slots;
    logic [63:0] ln, dn, rd, by;
    bit          aborted, stable;
    logic [7:0]  got;
    logic [8:0]  exp;
    logic        doneOk, hsOk;
    string       tag;
    tag   = (w == 0) ? "A" : "B";
    slots = 10 + par;
    total = slots * div;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) continue;
      if (lineOf(w) !== 1'b0) continue;
      aborted = 0;
      ln = '0; dn = '0; rd = '0; by = '0;
      for (int c = 0; c < total; c++) begin
        if (c > 0) @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1;
          break;
        end
        ln[c] = lineOf(w);
        dn[c] = doneOf(w);
        rd[c] = readyOf(w);
        by[c] = busyOf(w);
      end
      if (aborted) continue;
      stable = 1;
      for (int s = 0; s < slots; s++)
        for (int k = 1; k < div; k++)
          if (ln[s*div+k] !== ln[s*div]) stable = 0;
      for (int i = 0; i < 8; i++) got[i] = ln[(1+i)*div];
      doneOk = (dn[total-1] === 1'b1);
      hsOk   = 1'b1;
      for (int c = 0; c < total; c++) begin
        if (c < total - 1 && dn[c] !== 1'b0) doneOk = 1'b0;
        if (rd[c] !== 1'b0 || by[c] !== 1'b1) hsOk = 1'b0;
      end
      if (((w == 0) ? qA.size() : qB.size()) == 0) begin
        errors++;
        checks++;
        $display("[TB] FAIL %s unexpected frame: data %0h, expected no frame", tag, got);
      end else begin
        exp = (w == 0) ? qA.pop_front() : qB.pop_front();
        checkOutput({tag, " data"}, {24'd0, got}, {24'd0, exp[7:0]});
        if (par != 0) checkOutput({tag, " parity"}, {31'd0, ln[9*div]}, {31'd0, exp[8]});
        checkOutput({tag, " stop"}, {31'd0, ln[(slots-1)*div]}, 32'd1);
        checkOutput({tag, " bit stable"}, {31'd0, stable}, 32'd1);
        checkOutput({tag, " done at frame end"}, {31'd0, doneOk}, 32'd1);
        checkOutput({tag, " ready low busy high"}, {31'd0, hsOk}, 32'd1);
      end
      @(negedge clk);
      if (rst_n === 1'b1) checkOutput({tag, " idle gap"}, {31'd0, lineOf(w)}, 32'd1);
    end
  endtask

  initial monitorLink(0, 4, 1);
  initial monitorLink(1, 1, 0);

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifA.in_valid = 1'b1; ifA.in_data = 8'hA5;
    ifB.in_valid = 1'b0; ifB.in_data = 8'h00;

    // Reset with a word offered: nothing accepted, line idle high.
    repeat (3) @(negedge clk);
    checkOutput("reset A line", {31'd0, lineA}, 32'd1);
    checkOutput("reset A ready", {31'd0, ifA.in_ready}, 32'd1);
    checkOutput("reset A busy", {31'd0, busyA}, 32'd0);
    checkOutput("reset A done", {31'd0, doneA}, 32'd0);
    checkOutput("reset B line", {31'd0, lineB}, 32'd1);
    checkOutput("reset B ready", {31'd0, ifB.in_ready}, 32'd1);
    ifA.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post-reset A busy", {31'd0, busyA}, 32'd0);
    checkOutput("post-reset A line", {31'd0, lineA}, 32'd1);

    // 8'hA5: four ones -> parity 0; 8'h01 -> 1; 8'h03 -> 0.
    applyStimulus(0, 8'hA5, 1'b0, 1, 0);
    waitDrain(0);
    applyStimulus(0, 8'h01, 1'b1, 1, 0);
    waitDrain(0);
    applyStimulus(0, 8'h03, 1'b0, 1, 0);
    waitDrain(0);

    // Input changes mid-frame are ignored; 8'h3C is sent.
    applyStimulus(0, 8'h3C, 1'b0, 1, 0);
    ifA.in_data  = 8'hC3;
    ifA.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("A ready low while busy", {31'd0, ifA.in_ready}, 32'd0);
    ifA.in_valid = 1'b0;
    waitDrain(0);

    // Link B: valid held across two words, back-to-back 10-clock frames.
    applyStimulus(1, 8'hFF, 1'b0, 1, 1);
    applyStimulus(1, 8'h00, 1'b0, 1, 0);
    waitDrain(1);

    // 8'h55 bit3 = 0: reset during bit 3 forces the line high at once.
    applyStimulus(0, 8'h55, 1'b0, 0, 0);
    repeat (17) @(posedge clk);
    #2;
    checkOutput("A line in bit3", {31'd0, lineA}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset A line", {31'd0, lineA}, 32'd1);
    checkOutput("async reset A busy", {31'd0, busyA}, 32'd0);
    checkOutput("async reset A ready", {31'd0, ifA.in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("after abort A line", {31'd0, lineA}, 32'd1);
    checkOutput("after abort A busy", {31'd0, busyA}, 32'd0);

    // Fresh frame after the aborted one: 8'h81 -> parity 0.
    applyStimulus(0, 8'h81, 1'b0, 1, 0);
    waitDrain(0);

    checkOutput("A queue drained", qA.size(), 32'd0);
    checkOutput("B queue drained", qB.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
